// File: rtl/hyperbus_wb_bridge.sv
// Wishbone B4 classic 32-bit slave feeding the hyperbus leader request/stream port.
// Each bus cycle becomes one low-then-high halfword burst, followed by an idle gap.
module hyperbus_wb_bridge #(
    parameter int ADDR_LENGTH = 32,
    parameter int REG_BIT     = 31,
    parameter int TIMEOUT     = 64,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [31:0]            wb_adr_i,
    input  logic [31:0]            wb_dat_i,
    input  logic [3:0]             wb_sel_i,
    input  logic                   wb_we_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    output logic [31:0]            wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic [ADDR_LENGTH-1:0] hb_adr_o,
    output logic [15:0]            hb_dat_o,
    output logic [2:0]             hb_mask_o,
    output logic                   hb_reg_space_o,
    output logic                   hb_wrq_o,
    output logic                   hb_rrq_o,
    input  logic [15:0]            hb_dat_i,
    input  logic                   hb_ready_i,
    input  logic                   hb_valid_i
);
    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, WR_WAIT, WR_HI, RD_LO, RD_HI, GAP} state_t;

    state_t                 r_state, w_state_nx;
    logic [CW-1:0]          r_cnt, w_cnt_nx;
    logic [15:0]            r_dat_hi, w_dat_hi_nx;
    logic [1:0]             r_sel_hi, w_sel_hi_nx;
    logic [31:0]            w_adr_word;
    logic                   w_abort;
    logic [31:0]            w_wb_dat_nx;
    logic                   w_ack_nx, w_err_nx;
    logic [ADDR_LENGTH-1:0] w_hb_adr_nx;
    logic [15:0]            w_hb_dat_nx;
    logic [2:0]             w_mask_nx;
    logic                   w_reg_nx, w_wrq_nx, w_rrq_nx;

    // Register-space select bit and byte offset are stripped before halving to a word address.
    always_comb begin
        w_adr_word          = wb_adr_i;
        w_adr_word[REG_BIT] = 1'b0;
        w_adr_word[1:0]     = 2'b00;
    end

    always_comb begin
        w_abort = !wb_cyc_i && (r_state inside {WR_WAIT, WR_HI, RD_LO, RD_HI});
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_dat_hi_nx = r_dat_hi;
        w_sel_hi_nx = r_sel_hi;
        w_wb_dat_nx = wb_dat_o;
        w_ack_nx    = 1'b0;
        w_err_nx    = 1'b0;
        w_hb_adr_nx = hb_adr_o;
        w_hb_dat_nx = hb_dat_o;
        w_mask_nx   = hb_mask_o;
        w_reg_nx    = hb_reg_space_o;
        w_wrq_nx    = hb_wrq_o;
        w_rrq_nx    = hb_rrq_o;
        if (w_abort) begin
            w_wrq_nx   = 1'b0;
            w_rrq_nx   = 1'b0;
            w_mask_nx  = 3'b011;
            w_cnt_nx   = '0;
            w_state_nx = GAP;
        end else begin
            case (r_state)
                IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        w_hb_adr_nx = ADDR_LENGTH'(w_adr_word >> 1);
                        w_reg_nx    = wb_adr_i[REG_BIT];
                        if (wb_we_i) begin
                            w_wrq_nx    = 1'b1;
                            w_hb_dat_nx = wb_dat_i[15:0];
                            w_mask_nx   = {1'b0, ~wb_sel_i[1:0]};
                            w_dat_hi_nx = wb_dat_i[31:16];
                            w_sel_hi_nx = wb_sel_i[3:2];
                            w_state_nx  = WR_WAIT;
                        end else begin
                            w_rrq_nx   = 1'b1;
                            w_cnt_nx   = '0;
                            w_state_nx = RD_LO;
                        end
                    end
                end
                WR_WAIT: begin
                    if (hb_ready_i) begin
                        w_hb_dat_nx = r_dat_hi;
                        w_mask_nx   = {1'b0, ~r_sel_hi};
                        w_state_nx  = WR_HI;
                    end
                end
                WR_HI: begin
                    w_wrq_nx   = 1'b0;
                    w_mask_nx  = 3'b011;
                    w_ack_nx   = 1'b1;
                    w_cnt_nx   = '0;
                    w_state_nx = GAP;
                end
                RD_LO, RD_HI: begin
                    if (hb_valid_i) begin
                        w_cnt_nx = '0;
                        if (r_state == RD_LO) begin
                            w_wb_dat_nx[15:0] = hb_dat_i;
                            w_state_nx        = RD_HI;
                        end else begin
                            w_wb_dat_nx[31:16] = hb_dat_i;
                            w_rrq_nx           = 1'b0;
                            w_ack_nx           = 1'b1;
                            w_state_nx         = GAP;
                        end
                    end else if (r_cnt == CW'(TIMEOUT)) begin
                        w_rrq_nx   = 1'b0;
                        w_err_nx   = 1'b1;
                        w_cnt_nx   = '0;
                        w_state_nx = GAP;
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                GAP: begin
                    if (r_cnt >= CW'(GAP_CYCLES - 1)) begin
                        w_cnt_nx   = '0;
                        w_state_nx = IDLE;
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_cnt_nx   = '0;
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_dat_hi       <= '0;
            r_sel_hi       <= '0;
            wb_dat_o       <= '0;
            wb_ack_o       <= 1'b0;
            wb_err_o       <= 1'b0;
            hb_adr_o       <= '0;
            hb_dat_o       <= '0;
            hb_mask_o      <= 3'b011;
            hb_reg_space_o <= 1'b0;
            hb_wrq_o       <= 1'b0;
            hb_rrq_o       <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_cnt          <= w_cnt_nx;
            r_dat_hi       <= w_dat_hi_nx;
            r_sel_hi       <= w_sel_hi_nx;
            wb_dat_o       <= w_wb_dat_nx;
            wb_ack_o       <= w_ack_nx;
            wb_err_o       <= w_err_nx;
            hb_adr_o       <= w_hb_adr_nx;
            hb_dat_o       <= w_hb_dat_nx;
            hb_mask_o      <= w_mask_nx;
            hb_reg_space_o <= w_reg_nx;
            hb_wrq_o       <= w_wrq_nx;
            hb_rrq_o       <= w_rrq_nx;
        end
    end
endmodule

// File: doc/hyperbus_wb_bridge.md
# hyperbus_wb_bridge

Wishbone B4 classic 32-bit slave that turns each bus cycle into one two-word HyperBus burst on the request/stream interface of the `hyperbus` leader controller (WIDTH=8, 16-bit words). It sits directly upstream of `hyperbus`, in the same clock domain. It owns:
- address translation;
- halfword sequencing and byte masking;
- the read-data timeout;
- the mandatory idle gap between transactions.

## Interface
Parameters:
- ADDR_LENGTH, 32: width of hb_adr_o; matches `hyperbus` ADDR_LENGTH.
- REG_BIT, 31: wb_adr_i bit that selects HyperRAM register space.
- TIMEOUT, 64: max cycles waiting for each read word before error.
- GAP_CYCLES, 4: cycles both requests are held low after any transaction.

Ports:
- clk  in  1  memory clock, same clk as `hyperbus`.
- rstn  in  1  reset. One clock; reset is asynchronous and active-low.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte enables.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  single-cycle acknowledge.
- wb_err_o  out  1  single-cycle error (read timeout).
- hb_adr_o  out  ADDR_LENGTH  word address, to adr_i.
- hb_dat_o  out  16  write word, to dat_i.
- hb_mask_o  out  3  write mask, to mask_i. 1 = byte not written. [1] masks [15:8], [0] masks [7:0], [2] always 0.
- hb_reg_space_o  out  1  to reg_space_i.
- hb_wrq_o  out  1  to wrq.
- hb_rrq_o  out  1  to rrq.
- hb_dat_i  in  16  read word, from dat_o.
- hb_ready_i  in  1  from ready; one write word is consumed every cycle it is high.
- hb_valid_i  in  1  from valid; hb_dat_i is valid this cycle.

## Operation
- All outputs are registered.
- Reset values:
  - wb_dat_o=0, wb_ack_o=0, wb_err_o=0;
  - hb_adr_o=0, hb_dat_o=0, hb_mask_o=3'b011, hb_reg_space_o=0;
  - hb_wrq_o=0, hb_rrq_o=0;
  - state IDLE, counters 0.
- Address: on acceptance, hb_adr_o = (wb_adr_i with bit REG_BIT cleared) >> 1, zero-extended/truncated to ADDR_LENGTH. hb_reg_space_o = wb_adr_i[REG_BIT]. wb_adr_i[1:0] are ignored; accesses are word aligned.
- Halfword order: low half first at the word address, high half second.
- States: IDLE, WR_WAIT, WR_HI, RD_LO, RD_HI, GAP.
- IDLE, on wb_cyc_i & wb_stb_i:
  - Write: hb_wrq_o<=1; hb_dat_o<=wb_dat_i[15:0]; hb_mask_o<={1'b0,~wb_sel_i[1:0]}; latch upper data/sel. Go to WR_WAIT.
  - Read: hb_rrq_o<=1; timeout counter<=0. Go to RD_LO.
- WR_WAIT: when hb_ready_i, load hb_dat_o<=upper 16 bits and hb_mask_o<={1'b0,~sel[3:2]}. Go to WR_HI.
- WR_HI (one cycle): hb_wrq_o<=0; hb_mask_o<=3'b011 so any trailing controller word is masked; wb_ack_o<=1. Go to GAP.
- RD_LO: on hb_valid_i, wb_dat_o[15:0]<=hb_dat_i, reset timeout counter, go to RD_HI.
- RD_HI: on hb_valid_i, wb_dat_o[31:16]<=hb_dat_i, hb_rrq_o<=0, wb_ack_o<=1, go to GAP.
- Timeout: in RD_LO/RD_HI the counter increments each cycle without hb_valid_i. On reaching TIMEOUT: hb_rrq_o<=0, wb_err_o<=1, wb_dat_o unchanged, go to GAP.
- Abort: wb_cyc_i low in WR_WAIT/WR_HI/RD_LO/RD_HI drops both requests, masks all bytes, and goes to GAP with no ack/err. A partially written word is not rolled back.
- GAP: requests held low for GAP_CYCLES, then IDLE. Wishbone requests arriving during GAP wait, stalled with no ack; they are accepted on IDLE.
- hb_wrq_o and hb_rrq_o are never high together.
- Asserting rstn low at any time returns every output to its reset value immediately.

## Timing
- Write latency: ack is registered 2 cycles after the first cycle hb_ready_i is high. hb_ready_i must stay high for WR_HI; it is sampled only in WR_WAIT.
- Read: ack is registered the cycle after the second hb_valid_i. Non-consecutive valid pulses are fine.
- Ack/err pulse width is exactly 1 cycle.
- Minimum request-low time between transactions: GAP_CYCLES+1 cycles.

## Test plan
- Write 0xDEADBEEF to byte address 0x0000_0010, sel=4'hF, ready high from cycle 5:
  - hb_adr_o=0x8, wrq high;
  - dat 0xBEEF then 0xDEAD on consecutive ready cycles, mask 3'b000 both;
  - ack 1 cycle, then mask=3'b011.
- Write sel=4'b0110, data 0x11223344: masks 3'b001 (low word), then 3'b010 (high word).
- Read 0x8000_0004, valid with 0x5678 then 0x1234 three cycles apart:
  - reg_space=1, hb_adr_o=0x2;
  - wb_dat_o=0x12345678, single ack, rrq low.
- Read, no valid for 64 cycles: err pulse at cycle 65 after acceptance, rrq drops, no ack.
- Back-to-back reads: second rrq rises no earlier than GAP_CYCLES+1 cycles after the first falls.
- rstn low mid-write in WR_HI: wrq=0, ack=0, mask=3'b011 immediately. After release, a new read is accepted normally.
